// File: rtl/rx_gearbox_blk_sync.sv
// 10GBASE-R receive gearbox and block synchroniser: packs 32-bit PMA words into
// 66-bit blocks and hunts for sync-header alignment with a one-bit slip.
module rx_gearbox_blk_sync #(
  parameter int SH_CNT_MAX   = 64,
  parameter int SH_INVLD_MAX = 16,
  parameter int SLIP_HOLD    = 4
) (
  input  logic        clk_rx,
  input  logic        rst_rx_n,
  input  logic [31:0] pma_rx,
  input  logic        pma_rx_rdy,
  output logic [65:0] blk_data,
  output logic        blk_vld,
  output logic        blk_lock,
  output logic [15:0] slip_cnt,
  output logic [1:0]  dbg_state
);

  localparam int SH_W = $clog2(SH_CNT_MAX + 1);
  localparam int IV_W = $clog2(SH_INVLD_MAX + 1);
  localparam int HD_W = $clog2(SLIP_HOLD + 1);

  typedef enum logic [1:0] {
    LOCK_INIT = 2'd0,
    TEST      = 2'd1,
    SLIP      = 2'd2,
    HOLD      = 2'd3
  } state_t;

  state_t      state_q;
  logic [96:0] buf_q;
  logic [6:0]  fill_q;
  logic [65:0] blk_data_q;
  logic        blk_vld_q;
  logic        blk_lock_q;
  logic [15:0] slip_cnt_q;
  logic [SH_W-1:0] sh_cnt_q;
  logic [IV_W-1:0] invld_cnt_q;
  logic [HD_W-1:0] hold_cnt_q;

  logic        slip;
  logic [96:0] merged;
  logic [7:0]  tot;
  logic        emit;
  logic        hdr_ok;
  logic [SH_W-1:0] sh_nxt;
  logic [IV_W-1:0] inv_nxt;

  // The slip drops the oldest buffered bit, moving the block boundary one bit later.
  always_comb begin
    slip   = (state_q == SLIP);
    merged = buf_q | ({65'd0, pma_rx} << fill_q);
    tot    = {1'b0, fill_q} + 8'd32;
    if (slip) begin
      merged = merged >> 1;
      tot    = tot - 8'd1;
    end
    emit    = (tot >= 8'd66);
    hdr_ok  = blk_data_q[0] ^ blk_data_q[1];
    sh_nxt  = sh_cnt_q + SH_W'(1);
    inv_nxt = invld_cnt_q + {{(IV_W-1){1'b0}}, ~hdr_ok};
  end

  always_ff @(posedge clk_rx or negedge rst_rx_n) begin
    if (!rst_rx_n) begin
      buf_q      <= '0;
      fill_q     <= '0;
      blk_data_q <= '0;
      blk_vld_q  <= 1'b0;
    end else if (!pma_rx_rdy) begin
      buf_q      <= '0;
      fill_q     <= '0;
      blk_data_q <= '0;
      blk_vld_q  <= 1'b0;
    end else if (emit) begin
      blk_data_q <= merged[65:0];
      blk_vld_q  <= 1'b1;
      buf_q      <= merged >> 66;
      fill_q     <= 7'(tot - 8'd66);
    end else begin
      blk_vld_q  <= 1'b0;
      buf_q      <= merged;
      fill_q     <= tot[6:0];
    end
  end

  // LOCK_INIT leaves unconditionally; no block can be emitted on the first cycle.
  always_ff @(posedge clk_rx or negedge rst_rx_n) begin
    if (!rst_rx_n) begin
      state_q     <= LOCK_INIT;
      blk_lock_q  <= 1'b0;
      slip_cnt_q  <= '0;
      sh_cnt_q    <= '0;
      invld_cnt_q <= '0;
      hold_cnt_q  <= '0;
    end else if (!pma_rx_rdy) begin
      state_q     <= LOCK_INIT;
      blk_lock_q  <= 1'b0;
      sh_cnt_q    <= '0;
      invld_cnt_q <= '0;
      hold_cnt_q  <= '0;
    end else begin
      case (state_q)
        LOCK_INIT: begin
          blk_lock_q  <= 1'b0;
          sh_cnt_q    <= '0;
          invld_cnt_q <= '0;
          state_q     <= TEST;
        end
        TEST: begin
          if (blk_vld_q) begin
            if (!blk_lock_q) begin
              if (!hdr_ok) begin
                state_q <= SLIP;
              end else if (sh_nxt == SH_W'(SH_CNT_MAX)) begin
                blk_lock_q  <= 1'b1;
                sh_cnt_q    <= '0;
                invld_cnt_q <= '0;
              end else begin
                sh_cnt_q <= sh_nxt;
              end
            end else if (inv_nxt == IV_W'(SH_INVLD_MAX)) begin
              blk_lock_q <= 1'b0;
              state_q    <= SLIP;
            end else if (sh_nxt == SH_W'(SH_CNT_MAX)) begin
              sh_cnt_q    <= '0;
              invld_cnt_q <= '0;
            end else begin
              sh_cnt_q    <= sh_nxt;
              invld_cnt_q <= inv_nxt;
            end
          end
        end
        SLIP: begin
          if (slip_cnt_q != 16'hFFFF) slip_cnt_q <= slip_cnt_q + 16'd1;
          sh_cnt_q    <= '0;
          invld_cnt_q <= '0;
          hold_cnt_q  <= '0;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (blk_vld_q) begin
            if (hold_cnt_q == HD_W'(SLIP_HOLD - 1)) begin
              hold_cnt_q <= '0;
              state_q    <= TEST;
            end else begin
              hold_cnt_q <= hold_cnt_q + HD_W'(1);
            end
          end
        end
        default: state_q <= LOCK_INIT;
      endcase
    end
  end

  assign blk_data  = blk_data_q;
  assign blk_vld   = blk_vld_q;
  assign blk_lock  = blk_lock_q;
  assign slip_cnt  = slip_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rx_gearbox_blk_sync.sv
// Directed bench for rx_gearbox_blk_sync: feeds a serial block stream 32 bits per
// cycle and checks packing, lock acquisition/loss, slips, rdy drop and async reset.
module tb_rx_gearbox_blk_sync;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_SLIP = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  logic        clk_rx = 1'b0;
  logic        rst_rx_n = 1'b0;
  logic [31:0] pma_rx = '0;
  logic        pma_rx_rdy = 1'b1;
  logic [65:0] blk_data;
  logic        blk_vld;
  logic        blk_lock;
  logic [15:0] slip_cnt;
  logic [1:0]  dbg_state;

  rx_gearbox_blk_sync dut (
    .clk_rx     (clk_rx),
    .rst_rx_n   (rst_rx_n),
    .pma_rx     (pma_rx),
    .pma_rx_rdy (pma_rx_rdy),
    .blk_data   (blk_data),
    .blk_vld    (blk_vld),
    .blk_lock   (blk_lock),
    .slip_cnt   (slip_cnt),
    .dbg_state  (dbg_state)
  );

  always #5 clk_rx = ~clk_rx;

  int total_cnt = 0;
  int bad_cnt   = 0;

  logic        bit_q[$];
  logic [65:0] exp_q[$];
  int  sent_idx = 0;
  int  rcv_idx  = 0;
  int  vld_seen = 0;
  bit  sb_on    = 1'b0;
  bit  mode_ones = 1'b0;
  int  inv1_lo = 0, inv1_hi = -1, inv2_lo = 0, inv2_hi = -1;

  task automatic check_eq(input string tag, input logic [65:0] got, input logic [65:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [65:0] make_blk(input int idx);
    logic [31:0] a, b;
    logic [1:0]  hdr;
    if (mode_ones) return {64'hFFFF_FFFF_FFFF_FFFF, 2'b01};
    a   = 32'hA5C3_0000 ^ 32'(idx);
    b   = 32'h1234_5678 + 32'(idx) * 32'h9E37_79B9;
    hdr = idx[0] ? 2'b10 : 2'b01;
    if ((idx >= inv1_lo && idx <= inv1_hi) || (idx >= inv2_lo && idx <= inv2_hi))
      hdr = idx[1] ? 2'b11 : 2'b00;
    return {a, b, hdr};
  endfunction

  task automatic refill();
    logic [65:0] blk;
    while (bit_q.size() < 32) begin
      sent_idx++;
      blk = make_blk(sent_idx);
      for (int i = 0; i < 66; i++) bit_q.push_back(blk[i]);
      if (sb_on) exp_q.push_back(blk);
    end
  endtask

  // Drive one word at the current falling edge, then sample after the next one.
  task automatic step();
    logic [31:0] w;
    logic [65:0] exp;
    refill();
    w = '0;
    for (int i = 0; i < 32; i++) w[i] = bit_q.pop_front();
    pma_rx = w;
    @(negedge clk_rx);
    if (blk_vld) begin
      rcv_idx++;
      vld_seen++;
      if (sb_on) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check_eq("blk_data", blk_data, exp);
      end
    end
  endtask

  task automatic wait_blk(input int n, input string tag);
    int cyc;
    cyc = 0;
    while (rcv_idx < n && cyc < 3000) begin
      step();
      cyc++;
    end
    check_eq(tag, 66'(rcv_idx), 66'(n));
  endtask

  task automatic new_stream(input bit ones, input bit sb);
    bit_q.delete();
    exp_q.delete();
    sent_idx  = 0;
    rcv_idx   = 0;
    mode_ones = ones;
    sb_on     = sb;
    inv1_lo = 0; inv1_hi = -1; inv2_lo = 0; inv2_hi = -1;
  endtask

  task automatic async_reset_check(input string tag);
    #2 rst_rx_n = 1'b0;
    #1;
    check_eq({tag, "_data"}, blk_data, 66'd0);
    check_eq({tag, "_vld"}, 66'(blk_vld), 66'd0);
    check_eq({tag, "_lock"}, 66'(blk_lock), 66'd0);
    check_eq({tag, "_slip"}, 66'(slip_cnt), 66'd0);
    check_eq({tag, "_state"}, 66'(dbg_state), 66'(ST_INIT));
    @(negedge clk_rx);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, then aligned stream: packing, rate, lock, retention and loss.
    repeat (3) @(negedge clk_rx);
    check_eq("rst_data", blk_data, 66'd0);
    check_eq("rst_vld", 66'(blk_vld), 66'd0);
    check_eq("rst_lock", 66'(blk_lock), 66'd0);
    check_eq("rst_slip", 66'(slip_cnt), 66'd0);
    new_stream(1'b0, 1'b1);
    inv1_lo = 70;  inv1_hi = 84;
    inv2_lo = 140; inv2_hi = 155;
    rst_rx_n = 1'b1;
    wait_blk(5, "s1_blk5");
    vld_seen = 0;
    repeat (33) step();
    check_eq("s1_rate33", 66'(vld_seen), 66'd16);
    wait_blk(64, "s1_blk64");
    check_eq("s1_lock_at64", 66'(blk_lock), 66'd0);
    step();
    check_eq("s1_lock_after64", 66'(blk_lock), 66'd1);
    check_eq("s1_slip0", 66'(slip_cnt), 66'd0);
    wait_blk(129, "s3_blk129");
    check_eq("s3_lock_15inv", 66'(blk_lock), 66'd1);
    check_eq("s3_slip_15inv", 66'(slip_cnt), 66'd0);
    wait_blk(155, "s3_blk155");
    sb_on = 1'b0;
    check_eq("s3_lock_at16th", 66'(blk_lock), 66'd1);
    step();
    check_eq("s3_lock_lost", 66'(blk_lock), 66'd0);
    check_eq("s3_state_slip", 66'(dbg_state), 66'(ST_SLIP));
    step();
    check_eq("s3_slip1", 66'(slip_cnt), 66'd1);
    check_eq("s3_state_hold", 66'(dbg_state), 66'(ST_HOLD));

    // Async reset mid-cycle, then 16th invalid header on block 64 of the window.
    async_reset_check("s6a");
    new_stream(1'b0, 1'b1);
    inv1_lo = 113; inv1_hi = 128;
    rst_rx_n = 1'b1;
    wait_blk(65, "s4_blk65");
    check_eq("s4_locked", 66'(blk_lock), 66'd1);
    wait_blk(128, "s4_blk128");
    sb_on = 1'b0;
    check_eq("s4_lock_at64th", 66'(blk_lock), 66'd1);
    step();
    check_eq("s4_lock_lost", 66'(blk_lock), 66'd0);
    check_eq("s4_state_slip", 66'(dbg_state), 66'(ST_SLIP));
    step();
    check_eq("s4_slip1", 66'(slip_cnt), 66'd1);
    check_eq("s4_state_hold", 66'(dbg_state), 66'(ST_HOLD));

    // 37 garbage bits ahead of the stream: exactly 37 slips to reach alignment.
    async_reset_check("s6b");
    new_stream(1'b1, 1'b0);
    for (int i = 0; i < 37; i++) bit_q.push_back(1'b1);
    rst_rx_n = 1'b1;
    for (int c = 0; c < 3000 && !blk_lock; c++) step();
    check_eq("s2_lock", 66'(blk_lock), 66'd1);
    check_eq("s2_slip37", 66'(slip_cnt), 66'd37);
    for (int k = 0; k < 6; k++) begin
      wait_blk(rcv_idx + 1, "s2_next_blk");
      check_eq("s2_hdr", 66'(blk_data[1:0]), 66'(2'b01));
      check_eq("s2_blk", blk_data, {64'hFFFF_FFFF_FFFF_FFFF, 2'b01});
    end

    // Drop pma_rx_rdy while locked: sync clear but slip_cnt held, then relock.
    repeat (7) step();
    pma_rx_rdy = 1'b0;
    @(negedge clk_rx);
    check_eq("s5_vld", 66'(blk_vld), 66'd0);
    check_eq("s5_lock", 66'(blk_lock), 66'd0);
    check_eq("s5_slip_held", 66'(slip_cnt), 66'd37);
    check_eq("s5_state", 66'(dbg_state), 66'(ST_INIT));
    repeat (3) @(negedge clk_rx);
    new_stream(1'b0, 1'b1);
    pma_rx_rdy = 1'b1;
    wait_blk(64, "s5_blk64");
    check_eq("s5_lock_at64", 66'(blk_lock), 66'd0);
    step();
    check_eq("s5_relock", 66'(blk_lock), 66'd1);
    check_eq("s5_slip_after", 66'(slip_cnt), 66'd37);

    // Async reset from a locked state with nonzero slip count, then clean relock.
    async_reset_check("s6c");
    new_stream(1'b0, 1'b1);
    rst_rx_n = 1'b1;
    wait_blk(64, "s6_blk64");
    step();
    check_eq("s6_relock", 66'(blk_lock), 66'd1);
    check_eq("s6_slip0", 66'(slip_cnt), 66'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
